seq_alu: RTL
============

// Module: seq_alu
// PURPOSE
//  Parametrised multi-cycle successor to the processor's single-cycle ALU core.
//  Logic and add/sub ops finish in 1 cycle; multiply and divide run as iterative
//  shift-add and restoring-divide units.
//  Valid/ready on operands and result, so the pipeline can stall on long ops.
//  Sits between the register-read stage and writeback.
// PARAMETERS
//  WIDTH     64  operand/result width in bits (>=4)
//  CNT_W     $clog2(WIDTH)+1  iteration counter width (derived, not overridden)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operands and sel are valid this cycle
//  in_ready   out  1      block can accept an operation (high only in IDLE)
//  sel        in   3      000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 xor, 111 slt
//  a_in       in   WIDTH  operand A
//  b_in       in   WIDTH  operand B
//  out_valid  out  1      result/flags valid; held until out_ready
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  sum/diff/low product/quotient/logic/slt (0 or 1)
//  remainder  out  WIDTH  div remainder; 0 for all other ops
//  z_f        out  1      result == 0
//  o_f        out  1      overflow: signed add/sub ovf; mul high half != 0; div by zero
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; in_ready=1, out_valid=0.
//    result, remainder, z_f and o_f are all 0; counter=0.
//  - Accept: in_valid & in_ready at edge. Operands and sel are registered; inputs
//    are ignored afterward.
//  - FSM: IDLE -> (sel=010) MUL | (sel=011) DIV | else DONE.
//    MUL/DIV -> DONE when counter hits WIDTH-1. DONE -> IDLE on out_ready.
//  - Latency from accept to out_valid: 1 cycle for single-cycle ops.
//    WIDTH+1 cycles for mul/div (WIDTH iterations plus 1 load cycle).
//  - Add/sub are WIDTH-bit wraparound; sub = a + ~b + 1.
//    o_f = signed overflow (sign(a)==sign(b') and sign(res)!=sign(a)).
//  - slt: signed compare a<b; result = {WIDTH-1 zeros, lt}; o_f=0.
//  - mul: unsigned. A 2*WIDTH product is accumulated; result = low WIDTH bits.
//    o_f = |high WIDTH bits.
//  - div: unsigned restoring, one quotient bit per cycle.
//    b_in==0: result = all ones, remainder = a_in, o_f=1, still WIDTH+1 cycles.
//  - Logic ops: o_f=0, remainder=0.
//  - z_f is computed from the final registered result, never from a previous op.
//  - Outputs are stable while out_valid=1 and out_ready=0 (backpressure).
//    No new accept until the result drains.
//  - out_ready & out_valid moves DONE->IDLE. in_ready rises the next cycle; no
//    same-cycle accept/complete overlap.
//  - in_valid while busy: ignored (in_ready=0), no side effects.
//  - rst mid-operation: op aborted, no out_valid pulse, all outputs return to reset values.
//  - sel=xxx/unknown never reaches FSM: decode treats any value not listed as add.
// STRUCTURE
//  - alu_pkg: opcode localparams (OP_ADD..OP_SLT) and state encoding
//    (ST_IDLE, ST_MUL, ST_DIV, ST_DONE). Shared with decode stage.
//  - Sub-module seq_muldiv_core: iterative mul/div datapath.
//    Interface: start, is_div, a, b -> done, lo, hi, div0. Owns counter and shift regs.
//  - Top holds FSM, 1-cycle ops, flag logic, output registers.
// TESTING
//  - Reset mid-MUL at cycle 5 -> out_valid stays 0, in_ready=1 next cycle, result=0.
//  - add 0x7FFF_FFFF_FFFF_FFFF + 1 -> result 0x8000_0000_0000_0000, o_f=1, z_f=0, 1 cycle.
//  - sub 5-5 -> result 0, z_f=1, o_f=0; slt -1 vs 1 -> result 1.
//  - mul 0xFFFF_FFFF x 0x1_0000_0001 -> result 0xFFFF_FFFF_FFFF_FFFF, o_f=0, 65 cycles.
//    mul 2^63 x 2 -> result 0, o_f=1, z_f=1.
//  - div 100/7 -> result 14, remainder 2. div 9/0 -> result all ones, remainder 9,
//    o_f=1, 65 cycles.
//  - Hold out_ready=0 for 10 cycles after done -> outputs constant, in_ready=0,
//    in_valid pulses ignored. Then release -> next op accepted.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings, sequencer state encoding and the sel decoder
// used by both the decode stage and seq_alu.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Anything that is not a clean opcode (X/Z bits) falls back to add.
    function automatic logic [2:0] decode_op(input logic [2:0] sel);
        case (sel)
            OP_ADD:  return OP_ADD;
            OP_SUB:  return OP_SUB;
            OP_MUL:  return OP_MUL;
            OP_DIV:  return OP_DIV;
            OP_AND:  return OP_AND;
            OP_OR:   return OP_OR;
            OP_XOR:  return OP_XOR;
            OP_SLT:  return OP_SLT;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative unsigned datapath: shift-add multiply and restoring divide, one
// bit per cycle. lo/hi present the values produced by the current iteration.
module seq_muldiv_core
    import alu_pkg::*;
#(
    parameter  int WIDTH = 64,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             div0
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic             busy_reg;
    logic             is_div_reg;
    logic             div0_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic             div_ge;
    logic [WIDTH-1:0] hi_next;
    logic [WIDTH-1:0] lo_next;

    // hi is the product accumulator / partial remainder; lo holds the
    // multiplier or dividend and fills with product / quotient bits.
    always_comb begin
        mul_sum   = {1'b0, hi_reg} + {1'b0, (lo_reg[0] ? mcand_reg : {WIDTH{1'b0}})};
        div_shift = {hi_reg, lo_reg[WIDTH-1]};
        div_trial = div_shift - {1'b0, mcand_reg};
        div_ge    = ~div_trial[WIDTH];
        if (is_div_reg) begin
            hi_next = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
            lo_next = {lo_reg[WIDTH-2:0], div_ge};
        end else begin
            hi_next = mul_sum[WIDTH:1];
            lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg   <= 1'b0;
            is_div_reg <= 1'b0;
            div0_reg   <= 1'b0;
            cnt_reg    <= '0;
            mcand_reg  <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else if (start) begin
            busy_reg   <= 1'b1;
            is_div_reg <= is_div;
            div0_reg   <= (b == '0);
            cnt_reg    <= '0;
            mcand_reg  <= b;
            hi_reg     <= '0;
            lo_reg     <= a;
        end else if (busy_reg) begin
            hi_reg  <= hi_next;
            lo_reg  <= lo_next;
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (cnt_reg == LAST) begin
                busy_reg <= 1'b0;
            end
        end
    end

    assign done = busy_reg && (cnt_reg == LAST);
    assign lo   = lo_next;
    assign hi   = hi_next;
    assign div0 = div0_reg;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle add/sub/logic/slt, iterative mul/div, with
// valid/ready handshakes on operands and result.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             z_f,
    output logic             o_f
);

    state_t           state_reg;
    logic [2:0]       op;
    logic             accept;
    logic             start;
    logic             is_div;
    logic             sub_op;
    logic             lt;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] fast_res;
    logic             fast_ovf;

    logic             core_done;
    logic             core_div0;
    logic [WIDTH-1:0] core_lo;
    logic [WIDTH-1:0] core_hi;

    always_comb begin
        op       = decode_op(sel);
        accept   = in_valid && (state_reg == ST_IDLE);
        is_div   = (op == OP_DIV);
        start    = accept && ((op == OP_MUL) || (op == OP_DIV));
        sub_op   = (op == OP_SUB);
        b_eff    = sub_op ? ~b_in : b_in;
        sum      = a_in + b_eff + {{(WIDTH-1){1'b0}}, sub_op};
        lt       = $signed(a_in) < $signed(b_in);
        fast_res = sum;
        fast_ovf = (a_in[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_in[WIDTH-1]);
        case (op)
            OP_AND: begin fast_res = a_in & b_in; fast_ovf = 1'b0; end
            OP_OR:  begin fast_res = a_in | b_in; fast_ovf = 1'b0; end
            OP_XOR: begin fast_res = a_in ^ b_in; fast_ovf = 1'b0; end
            OP_SLT: begin fast_res = {{(WIDTH-1){1'b0}}, lt}; fast_ovf = 1'b0; end
            default: ;
        endcase
    end

    seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .is_div (is_div),
        .a      (a_in),
        .b      (b_in),
        .done   (core_done),
        .lo     (core_lo),
        .hi     (core_hi),
        .div0   (core_div0)
    );

    // Result registers only load on entry to DONE, so they stay frozen
    // under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            remainder <= '0;
            z_f       <= 1'b0;
            o_f       <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (op == OP_MUL) begin
                            state_reg <= ST_MUL;
                        end else if (op == OP_DIV) begin
                            state_reg <= ST_DIV;
                        end else begin
                            state_reg <= ST_DONE;
                            out_valid <= 1'b1;
                            result    <= fast_res;
                            remainder <= '0;
                            z_f       <= (fast_res == '0);
                            o_f       <= fast_ovf;
                        end
                    end
                end
                ST_MUL: begin
                    if (core_done) begin
                        state_reg <= ST_DONE;
                        out_valid <= 1'b1;
                        result    <= core_lo;
                        remainder <= '0;
                        z_f       <= (core_lo == '0);
                        o_f       <= |core_hi;
                    end
                end
                ST_DIV: begin
                    if (core_done) begin
                        state_reg <= ST_DONE;
                        out_valid <= 1'b1;
                        result    <= core_lo;
                        remainder <= core_hi;
                        z_f       <= (core_lo == '0);
                        o_f       <= core_div0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_reg <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
